// File: rtl/prog_mem_loader.sv
// Instruction memory for the single-cycle core, filled at run time over a valid/ready load port.
// Define PROG_MEM_RANGE_CHECK_EN to flag misaligned or out-of-range fetches on `fault`.
module prog_mem_loader #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 64,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD   = 32'hE1A00000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   a,
    output logic [DATA_WIDTH-1:0]   rd,
    input  logic                    ld_start,
    input  logic                    ld_valid,
    input  logic [DATA_WIDTH-1:0]   ld_data,
    input  logic                    ld_last,
    output logic                    ld_ready,
    output logic                    ld_done,
    output logic [$clog2(DEPTH):0]  ld_count,
    output logic                    busy,
    output logic                    fault
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   wptr_q, wptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            wr_en;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [IW-1:0]         rd_idx;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  fault_c;

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        count_d = count_q;
        wr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ld_start) begin
                    state_d = ST_LOAD;
                    wptr_d  = '0;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    wr_en   = 1'b1;
                    wptr_d  = wptr_q + 1'b1;
                    count_d = count_q + 1'b1;
                    // Stopping on the last slot keeps a long stream from wrapping onto word 0.
                    if (ld_last || (wptr_q == {IW{1'b1}})) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            count_q <= count_d;
        end
    end

    // Program storage has no reset so a reset mid-load keeps the words already written.
    always_ff @(posedge clk) begin
        if (wr_en && !reset) begin
            mem_q[wptr_q] <= ld_data;
        end
    end

    assign ld_ready = (state_q == ST_LOAD);
    assign ld_done  = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);
    assign ld_count = count_q;

    assign rd_idx  = a[IW+1:2];
    assign rd_word = mem_q[rd_idx];

`ifdef PROG_MEM_RANGE_CHECK_EN
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  fault_seen_q, fault_seen_d;

    assign word_addr = a >> 2;
    assign fault_c   = (a[1:0] != 2'b00) || (word_addr >= ADDR_WIDTH'(DEPTH));

    always_comb begin
        fault_seen_d = fault_seen_q | fault_c;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fault_seen_q <= 1'b0;
        end else begin
            fault_seen_q <= fault_seen_d;
        end
    end
`else
    logic unused_addr_bits;

    assign fault_c          = 1'b0;
    assign unused_addr_bits = ^{a[ADDR_WIDTH-1:IW+2], a[1:0]};
`endif

    assign fault = fault_c;
    assign rd    = (busy || fault_c) ? NOP_WORD : rd_word;

endmodule
